// File: rtl/stick_center_calibrator_if.sv
// Controller-poll inputs and committed-centre/status outputs of the stick centre calibrator.
// Latency: none (wiring only). Backpressure: none; polls are strobes that the calibrator always accepts.
interface stick_center_calibrator_if;
    logic       sample_valid;
    logic [7:0] JOY_X;
    logic [7:0] JOY_Y;
    logic [7:0] C_STICK_X;
    logic [7:0] C_STICK_Y;
    logic       start_pause;
    logic [7:0] joy_x_center;
    logic [7:0] joy_y_center;
    logic [7:0] c_stick_x_center;
    logic [7:0] c_stick_y_center;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;

    modport master (
        output sample_valid, JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, start_pause,
        input  joy_x_center, joy_y_center, c_stick_x_center, c_stick_y_center,
        input  cal_busy, cal_done, cal_fail
    );

    modport slave (
        input  sample_valid, JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, start_pause,
        output joy_x_center, joy_y_center, c_stick_x_center, c_stick_y_center,
        output cal_busy, cal_done, cal_fail
    );
endinterface

// File: rtl/stick_center_calibrator.sv
// Stick resting-centre calibration: START-hold arm, averaged window, atomic commit (CAL_RANGE_CHECK_EN adds a range gate).
// Latency: centres and cal_done update one edge after the final accepted poll; all outputs registered.
// Backpressure: none; polls are only examined on sample_valid, every other cycle holds state.
module stick_center_calibrator #(
    parameter int HOLD_SAMPLES   = 8,
    parameter int AVG_LOG2       = 4,
    parameter int TOLERANCE      = 6,
    parameter int RANGE          = 24,
    parameter int DEFAULT_CENTER = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    stick_center_calibrator_if.slave  bus
);

    localparam int NUM_SAMP = 1 << AVG_LOG2;
    localparam int ACC_W    = 8 + AVG_LOG2;
    localparam int HOLD_W   = $clog2(HOLD_SAMPLES + 1);
    localparam int CNT_W    = AVG_LOG2 + 1;
    localparam logic [ACC_W-1:0] ROUND      = ACC_W'(NUM_SAMP / 2);
    localparam logic [7:0]       CENTER_RST = 8'(DEFAULT_CENTER);

`ifdef CAL_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SAMPLE,
        COMMIT,
        FAIL,
        WAIT_RELEASE
    } state_t;

    state_t                      state_q, state_d;
    logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]            samp_cnt_q, samp_cnt_d;
    logic [3:0][7:0]             ref_q, ref_d;
    logic [3:0][ACC_W-1:0]       acc_q, acc_d;
    logic [3:0][7:0]             center_q, center_d;
    logic                        cal_busy_q, cal_busy_d;
    logic                        cal_done_q, cal_done_d;
    logic                        cal_fail_q, cal_fail_d;

    logic [3:0][7:0]             samp;
    logic [3:0][7:0]             diff;
    logic [3:0][7:0]             avg;
    logic                        out_of_tol;
    logic                        out_of_range;
    logic                        commit_fail;
    logic                        poll_hold;
    logic                        poll_release;
    logic                        first_poll;
    logic                        last_poll;

    // Axis order everywhere: 0 = JOY_X, 1 = JOY_Y, 2 = C_STICK_X, 3 = C_STICK_Y.
    assign samp         = {bus.C_STICK_Y, bus.C_STICK_X, bus.JOY_Y, bus.JOY_X};
    assign poll_hold    = bus.sample_valid && bus.start_pause;
    assign poll_release = bus.sample_valid && !bus.start_pause;
    assign first_poll   = (samp_cnt_q == '0);
    assign last_poll    = (int'(samp_cnt_q) == NUM_SAMP - 1);

    always_comb begin
        diff         = '0;
        avg          = '0;
        out_of_tol   = 1'b0;
        out_of_range = 1'b0;
        for (int i = 0; i < 4; i++) begin
            diff[i] = (samp[i] >= ref_q[i]) ? (samp[i] - ref_q[i]) : (ref_q[i] - samp[i]);
            if (int'(diff[i]) > TOLERANCE) begin
                out_of_tol = 1'b1;
            end
            // Round-half-up average; cannot exceed 255 since acc <= 255 * NUM_SAMP.
            avg[i] = 8'((acc_q[i] + ROUND) >> AVG_LOG2);
            if ((int'(avg[i]) < DEFAULT_CENTER - RANGE) || (int'(avg[i]) > DEFAULT_CENTER + RANGE)) begin
                out_of_range = 1'b1;
            end
        end
        commit_fail = RANGE_CHECK_EN && out_of_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            samp_cnt_q <= '0;
            ref_q      <= '0;
            acc_q      <= '0;
            center_q   <= {4{CENTER_RST}};
            cal_busy_q <= 1'b0;
            cal_done_q <= 1'b0;
            cal_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            ref_q      <= ref_d;
            acc_q      <= acc_d;
            center_q   <= center_d;
            cal_busy_q <= cal_busy_d;
            cal_done_q <= cal_done_d;
            cal_fail_q <= cal_fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (poll_hold) begin
                    state_d = (HOLD_SAMPLES <= 1) ? SAMPLE : ARM;
                end
            end
            ARM: begin
                if (poll_release) begin
                    state_d = IDLE;
                end else if (poll_hold && (int'(hold_cnt_q) + 1 >= HOLD_SAMPLES)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // A START release outranks a tolerance violation on the same poll.
                if (poll_release) begin
                    state_d = IDLE;
                end else if (poll_hold) begin
                    if (!first_poll && out_of_tol) begin
                        state_d = FAIL;
                    end else if (last_poll) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT:       state_d = commit_fail ? FAIL : WAIT_RELEASE;
            FAIL:         state_d = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (poll_release) begin
                    state_d = IDLE;
                end
            end
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        samp_cnt_d = samp_cnt_q;
        ref_d      = ref_q;
        acc_d      = acc_q;
        center_d   = center_q;
        cal_done_d = 1'b0;
        cal_fail_d = 1'b0;
        cal_busy_d = (state_d == SAMPLE);
        case (state_q)
            IDLE: begin
                if (poll_hold) begin
                    hold_cnt_d = HOLD_W'(1);
                    samp_cnt_d = '0;
                end
            end
            ARM: begin
                if (poll_hold) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            SAMPLE: begin
                if (poll_hold) begin
                    if (first_poll) begin
                        for (int i = 0; i < 4; i++) begin
                            ref_d[i] = samp[i];
                            acc_d[i] = ACC_W'(samp[i]);
                        end
                        samp_cnt_d = CNT_W'(1);
                    end else if (!out_of_tol) begin
                        for (int i = 0; i < 4; i++) begin
                            acc_d[i] = acc_q[i] + ACC_W'(samp[i]);
                        end
                        samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                // All four centres load together or not at all.
                if (!commit_fail) begin
                    center_d   = avg;
                    cal_done_d = 1'b1;
                end
            end
            FAIL:    cal_fail_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.joy_x_center     = center_q[0];
    assign bus.joy_y_center     = center_q[1];
    assign bus.c_stick_x_center = center_q[2];
    assign bus.c_stick_y_center = center_q[3];
    assign bus.cal_busy         = cal_busy_q;
    assign bus.cal_done         = cal_done_q;
    assign bus.cal_fail         = cal_fail_q;

endmodule

// File: tb/tb_stick_center_calibrator.sv
// Directed bench for stick_center_calibrator: a poll-level window model checked every cycle plus literal expectations.
module tb_stick_center_calibrator;

    localparam int HOLD = 8;
    localparam int NAVG = 16;
    localparam int TOL  = 6;
    localparam int RNG  = 24;
    localparam int DEF  = 128;

`ifdef CAL_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stick_center_calibrator_if bus ();

    stick_center_calibrator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int busy_cnt = 0;

    // Model: 0 idle, 1 arming, 2 sampling, 3 waiting for START release.
    int          m_phase = 0;
    int          m_hold  = 0;
    logic [31:0] m_win[$];
    bit          m_commit_due = 1'b0;
    bit          m_fail_due   = 1'b0;
    logic [7:0]  m_center[4];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_fail = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_centres();
        return {bus.c_stick_y_center, bus.c_stick_x_center, bus.joy_y_center, bus.joy_x_center};
    endfunction

    function automatic logic [31:0] model_centres();
        return {m_center[3], m_center[2], m_center[1], m_center[0]};
    endfunction

    function automatic int window_avg(input int k);
        int sum = 0;
        foreach (m_win[j]) sum += int'(m_win[j][8*k +: 8]);
        return (sum + NAVG / 2) / NAVG;
    endfunction

    function automatic bit moved(input logic [31:0] cur);
        if (m_win.size() == 0) return 1'b0;
        for (int k = 0; k < 4; k++) begin
            int d = int'(cur[8*k +: 8]) - int'(m_win[0][8*k +: 8]);
            if (d > TOL || d < -TOL) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur;
        int a[4];
        bit bad;
        cur = {bus.C_STICK_Y, bus.C_STICK_X, bus.JOY_Y, bus.JOY_X};
        m_done = 1'b0;
        m_fail = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_hold = 0;
            m_win.delete();
            m_commit_due = 1'b0;
            m_fail_due = 1'b0;
            for (int k = 0; k < 4; k++) m_center[k] = 8'(DEF);
        end else if (m_commit_due) begin
            m_commit_due = 1'b0;
            bad = 1'b0;
            for (int k = 0; k < 4; k++) begin
                a[k] = window_avg(k);
                if (a[k] < DEF - RNG || a[k] > DEF + RNG) bad = 1'b1;
            end
            if (RANGE_EN && bad) m_fail_due = 1'b1;
            else begin
                for (int k = 0; k < 4; k++) m_center[k] = 8'(a[k]);
                m_done = 1'b1;
            end
        end else if (m_fail_due) begin
            m_fail_due = 1'b0;
            m_fail = 1'b1;
        end else if (bus.sample_valid) begin
            case (m_phase)
                0: if (bus.start_pause) begin
                    m_hold = 1;
                    m_win.delete();
                    m_phase = (HOLD <= 1) ? 2 : 1;
                end
                1: if (!bus.start_pause) m_phase = 0;
                   else begin
                       m_hold++;
                       if (m_hold >= HOLD) m_phase = 2;
                   end
                2: if (!bus.start_pause) m_phase = 0;
                   else if (moved(cur)) begin
                       m_fail_due = 1'b1;
                       m_phase = 3;
                   end else begin
                       m_win.push_back(cur);
                       if (m_win.size() == NAVG) begin
                           m_commit_due = 1'b1;
                           m_phase = 3;
                       end
                   end
                default: if (!bus.start_pause) m_phase = 0;
            endcase
        end
        m_busy = (m_phase == 2);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_centres", dut_centres(), model_centres());
            check("cyc_flags", {29'd0, bus.cal_busy, bus.cal_done, bus.cal_fail},
                  {29'd0, m_busy, m_done, m_fail});
            done_cnt += int'(bus.cal_done);
            fail_cnt += int'(bus.cal_fail);
            busy_cnt += int'(bus.cal_busy);
        end
    end

    task automatic poll(input bit st, input logic [7:0] jx, input logic [7:0] jy,
                        input logic [7:0] cx, input logic [7:0] cy, input int gap);
        bus.sample_valid = 1'b1;
        bus.start_pause  = st;
        bus.JOY_X = jx;
        bus.JOY_Y = jy;
        bus.C_STICK_X = cx;
        bus.C_STICK_Y = cy;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic arm(input int n);
        for (int i = 0; i < n; i++) poll(1'b1, 8'd128, 8'd128, 8'd128, 8'd128, i % 2);
    endtask

    task automatic release_start();
        poll(1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 2);
    endtask

    initial begin
        int d0, f0, b0;
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.start_pause = 1'b0;
        bus.JOY_X = 8'd0;
        bus.JOY_Y = 8'd0;
        bus.C_STICK_X = 8'd0;
        bus.C_STICK_Y = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_centres", dut_centres(), 32'h80808080);
        check("rst_flags", {29'd0, bus.cal_busy, bus.cal_done, bus.cal_fail}, 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        idle(2);

        // START released on hold poll 5
        d0 = done_cnt; f0 = fail_cnt; b0 = busy_cnt;
        arm(4);
        release_start();
        idle(3);
        check("abort_arm_busy", 32'(busy_cnt - b0), 32'd0);
        check("abort_arm_pulses", 32'(done_cnt - d0 + fail_cnt - f0), 32'd0);
        check("abort_arm_centres", dut_centres(), 32'h80808080);

        // Nominal window
        d0 = done_cnt;
        arm(HOLD);
        for (int i = 0; i < 8; i++) poll(1'b1, 8'd131, 8'd125, 8'd128, 8'd126, i % 3);
        check("win_busy_mid", {31'd0, bus.cal_busy}, 32'd1);
        for (int i = 8; i < 16; i++) poll(1'b1, 8'd131, 8'd125, 8'd128, 8'd126, i % 3);
        idle(4);
        check("win_centres", dut_centres(), 32'h7E807D83);
        check("win_model", model_centres(), 32'h7E807D83);
        check("win_done_cycles", 32'(done_cnt - d0), 32'd1);
        check("win_busy_after", {31'd0, bus.cal_busy}, 32'd0);
        release_start();

        // Stick moves by 9 on the 6th sample poll, START kept held afterwards
        d0 = done_cnt; f0 = fail_cnt;
        arm(HOLD);
        for (int i = 0; i < 5; i++) poll(1'b1, 8'd131, 8'd125, 8'd128, 8'd126, 1);
        poll(1'b1, 8'd140, 8'd125, 8'd128, 8'd126, 0);
        idle(3);
        check("tol_fail_pulse", 32'(fail_cnt - f0), 32'd1);
        b0 = busy_cnt;
        for (int i = 0; i < 20; i++) poll(1'b1, 8'd128, 8'd128, 8'd128, 8'd128, i % 2);
        check("tol_no_rearm", 32'(busy_cnt - b0), 32'd0);
        check("tol_single_fail", 32'(fail_cnt - f0), 32'd1);
        check("tol_no_done", 32'(done_cnt - d0), 32'd0);
        check("tol_centres", dut_centres(), 32'h7E807D83);
        release_start();

        // Off-centre average of 170 on JOY_X
        d0 = done_cnt; f0 = fail_cnt;
        arm(HOLD);
        for (int i = 0; i < 16; i++) poll(1'b1, 8'd170, 8'd125, 8'd128, 8'd126, i % 2);
        idle(4);
`ifdef CAL_RANGE_CHECK_EN
        check("range_fail", 32'(fail_cnt - f0), 32'd1);
        check("range_centres", dut_centres(), 32'h7E807D83);
`else
        check("range_done", 32'(done_cnt - d0), 32'd1);
        check("range_centres", dut_centres(), 32'h7E807DAA);
`endif
        release_start();

        // Rounding and tolerance edge: JOY 130/131 and 125/126, C_X 128/134 (diff exactly 6), C_Y 122
        arm(HOLD);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) poll(1'b1, 8'd130, 8'd125, 8'd128, 8'd122, 0);
            else            poll(1'b1, 8'd131, 8'd126, 8'd134, 8'd122, 1);
        end
        idle(4);
        check("round_centres", dut_centres(), 32'h7A837E83);
        check("round_model", model_centres(), 32'h7A837E83);
        release_start();

        // Reset on the 10th sample poll after a commit of 131
        d0 = done_cnt; f0 = fail_cnt;
        arm(HOLD);
        for (int i = 0; i < 9; i++) poll(1'b1, 8'd131, 8'd125, 8'd128, 8'd126, i % 2);
        reset = 1'b1;
        poll(1'b1, 8'd131, 8'd125, 8'd128, 8'd126, 0);
        reset = 1'b0;
        check("rst_mid_centres", dut_centres(), 32'h80808080);
        check("rst_mid_busy", {31'd0, bus.cal_busy}, 32'd0);
        idle(4);
        check("rst_mid_pulses", 32'(done_cnt - d0 + fail_cnt - f0), 32'd0);
        release_start();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
